// File: rtl/xm_pipe_pkg.sv
// Shared widths, record layout and state encoding for the
// X/M and M/W elastic pipeline stages.
package xm_pipe_pkg;

  localparam int IR_W_DEF   = 32;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef struct packed {
    logic [IR_W_DEF-1:0]   ir;
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] dataB;
    logic [ADDR_W_DEF-1:0] baddr;
    logic                  exc;
  } xm_rec_t;

  localparam int REC_W = IR_W_DEF + 2 * DATA_W_DEF + ADDR_W_DEF + 1;

  // Encoding is {out_valid, skid_valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } xm_state_e;

endpackage

// File: rtl/xm_rec_reg.sv
// Load-enabled record register; payload carries no reset.
module xm_rec_reg
  import xm_pipe_pkg::*;
#(
  parameter int W = REC_W
) (
  input  logic         clk,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    if (ld_i) q_o <= d_i;
  end

endmodule

// File: rtl/xm_stage_elastic.sv
// Elastic X/M pipeline latch: valid/ready, 2-entry skid, flush, freeze.
// Optional stall counter port enabled by XM_STAGE_STALL_CNT_EN.
module xm_stage_elastic
  import xm_pipe_pkg::*;
#(
  parameter int IR_W   = IR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_dataB,
  input  logic [ADDR_W-1:0] in_Baddr,
  input  logic              in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IR_W-1:0]   out_ir,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_dataB,
  output logic [ADDR_W-1:0] out_Baddr,
  output logic              out_exc
`ifdef XM_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int RW = IR_W + 2 * DATA_W + ADDR_W + 1;

  xm_state_e state_q, state_d;

  logic [RW-1:0] in_rec;
  logic [RW-1:0] out_rec;
  logic [RW-1:0] skid_rec;
  logic [RW-1:0] out_d;
  logic          out_ld;
  logic          skid_ld;
  logic          acc;
  logic          dlv;

  assign in_rec = {in_ir, in_result, in_dataB, in_Baddr, in_exc};

  assign acc = in_valid & ~state_q[0] & en;
  assign dlv = state_q[1] & out_ready & en;

  always_ff @(posedge clk) begin
    if (clr) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      if (flush) begin
        state_d = ST_EMPTY;
      end else begin
        unique case (state_q)
          ST_EMPTY: if (acc) state_d = ST_FULL1;
          ST_FULL1: begin
            if (dlv && !acc)      state_d = ST_EMPTY;
            else if (acc && !dlv) state_d = ST_FULL2;
          end
          ST_FULL2: if (dlv) state_d = ST_FULL1;
          default:  state_d = ST_EMPTY;
        endcase
      end
    end
  end

  // Reset clears the visible record by loading zeros, not by a register reset
  always_comb begin
    out_ld  = 1'b0;
    skid_ld = 1'b0;
    out_d   = in_rec;
    if (clr) begin
      out_ld = 1'b1;
      out_d  = '0;
    end else if (en && !flush) begin
      unique case (state_q)
        ST_EMPTY: out_ld = acc;
        ST_FULL1: begin
          out_ld  = acc & dlv;
          skid_ld = acc & ~dlv;
        end
        ST_FULL2: begin
          out_ld = dlv;
          out_d  = skid_rec;
        end
        default: out_ld = 1'b0;
      endcase
    end
  end

  xm_rec_reg #(.W(RW)) u_out_reg (
    .clk  (clk),
    .ld_i (out_ld),
    .d_i  (out_d),
    .q_o  (out_rec)
  );

  xm_rec_reg #(.W(RW)) u_skid_reg (
    .clk  (clk),
    .ld_i (skid_ld),
    .d_i  (in_rec),
    .q_o  (skid_rec)
  );

  assign {out_ir, out_result, out_dataB, out_Baddr, out_exc} = out_rec;

  assign out_valid = state_q[1] & en;
  assign in_ready  = ~state_q[0] & en;

`ifdef XM_STAGE_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (clr)
      stall_q <= '0;
    else if (en && state_q[1] && !out_ready && !(&stall_q))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_xm_stage_elastic.sv
// Directed table-driven bench for xm_stage_elastic.
// Stall counter section is active when XM_STAGE_STALL_CNT_EN is defined.
module tb_xm_stage_elastic;

  logic        clk;
  logic        clr;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic [31:0] in_result;
  logic [31:0] in_dataB;
  logic [4:0]  in_Baddr;
  logic        in_exc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_result;
  logic [31:0] out_dataB;
  logic [4:0]  out_Baddr;
  logic        out_exc;
`ifdef XM_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  xm_stage_elastic dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ir      (in_ir),
    .in_result  (in_result),
    .in_dataB   (in_dataB),
    .in_Baddr   (in_Baddr),
    .in_exc     (in_exc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ir     (out_ir),
    .out_result (out_result),
    .out_dataB  (out_dataB),
    .out_Baddr  (out_Baddr),
    .out_exc    (out_exc)
`ifdef XM_STAGE_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic        clr;
    logic        en;
    logic        flush;
    logic        iv;
    logic        ordy;
    logic [31:0] ir;
    logic        eov;
    logic        erdy;
    logic [31:0] eir;
  } vec_t;

  int nchk = 0;
  int nfail = 0;
  int dlv77 = 0;
  int dlvC = 0;
  vec_t v[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (out_ir == 32'h77) dlv77++;
      if (out_ir == 32'hCC || out_ir == 32'hC) dlvC++;
    end
  end

  function automatic logic [31:0] res_of(logic [31:0] ir);
    return ir * 32'd3;
  endfunction

  function automatic logic [31:0] datb_of(logic [31:0] ir);
    return {ir[15:0], ir[31:16]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply(vec_t x, string tag);
    logic [31:0] ir;
    @(negedge clk);
    ir        = x.ir;
    clr       = x.clr;
    en        = x.en;
    flush     = x.flush;
    in_valid  = x.iv;
    out_ready = x.ordy;
    in_ir     = ir;
    in_result = res_of(ir);
    in_dataB  = datb_of(ir);
    in_Baddr  = ir[6:2];
    in_exc    = ^ir;
    @(posedge clk);
    #1;
    ir = x.eir;
    chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, x.eov});
    chk({tag, " in_ready"}, {31'd0, in_ready}, {31'd0, x.erdy});
    chk({tag, " out_ir"}, out_ir, ir);
    chk({tag, " out_result"}, out_result, res_of(ir));
    chk({tag, " out_dataB"}, out_dataB, datb_of(ir));
    chk({tag, " out_Baddr"}, {27'd0, out_Baddr}, {27'd0, ir[6:2]});
    chk({tag, " out_exc"}, {31'd0, out_exc}, {31'd0, ^ir});
  endtask

  function automatic vec_t mk(logic c, logic e, logic f, logic iv,
                              logic rd, logic [31:0] ir, logic eov,
                              logic erdy, logic [31:0] eir);
    vec_t r;
    r.clr = c; r.en = e; r.flush = f; r.iv = iv; r.ordy = rd;
    r.ir = ir; r.eov = eov; r.erdy = erdy; r.eir = eir;
    return r;
  endfunction

  initial begin
    clr = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_ir = '0; in_result = '0; in_dataB = '0;
    in_Baddr = '0; in_exc = 1'b0;

    //        clr en fl iv rd ir          ov rdy exp_ir
    v.push_back(mk(1, 1, 0, 1, 0, 32'hDEAD, 0, 1, 32'h0));
    v.push_back(mk(1, 1, 0, 1, 0, 32'hDEAD, 0, 1, 32'h0));
    v.push_back(mk(0, 1, 0, 1, 0, 32'h55,   1, 1, 32'h55));
    v.push_back(mk(0, 1, 0, 0, 1, 32'h0,    0, 1, 32'h55));
    for (int i = 0; i < 8; i++)
      v.push_back(mk(0, 1, 0, 1, 1, 32'h100 + i, 1, 1, 32'h100 + i));
    v.push_back(mk(0, 1, 0, 0, 1, 32'h0,    0, 1, 32'h107));
    v.push_back(mk(0, 1, 0, 1, 0, 32'hAAAA, 1, 1, 32'hAAAA));
    v.push_back(mk(0, 1, 0, 1, 0, 32'hBBBB, 1, 0, 32'hAAAA));
    v.push_back(mk(0, 1, 0, 0, 1, 32'h0,    1, 1, 32'hBBBB));
    v.push_back(mk(0, 1, 0, 0, 1, 32'h0,    0, 1, 32'hBBBB));
    v.push_back(mk(0, 1, 0, 1, 0, 32'h11,   1, 1, 32'h11));
    v.push_back(mk(0, 1, 0, 1, 0, 32'h22,   1, 0, 32'h11));
    v.push_back(mk(0, 1, 1, 1, 0, 32'hC,    0, 1, 32'h11));
    v.push_back(mk(0, 1, 0, 1, 0, 32'h33,   1, 1, 32'h33));
    v.push_back(mk(0, 1, 1, 1, 0, 32'hCC,   0, 1, 32'h33));
    v.push_back(mk(0, 1, 0, 0, 1, 32'h0,    0, 1, 32'h33));
    v.push_back(mk(0, 1, 0, 1, 0, 32'h44,   1, 1, 32'h44));
    v.push_back(mk(1, 1, 1, 1, 0, 32'h55,   0, 1, 32'h0));
    v.push_back(mk(0, 1, 0, 0, 0, 32'h0,    0, 1, 32'h0));
    v.push_back(mk(0, 1, 0, 1, 1, 32'h77,   1, 1, 32'h77));
    for (int i = 0; i < 3; i++)
      v.push_back(mk(0, 0, 0, 1, 1, 32'h88, 0, 0, 32'h77));
    v.push_back(mk(0, 1, 0, 0, 1, 32'h0,    0, 1, 32'h77));
    v.push_back(mk(0, 1, 0, 0, 1, 32'h0,    0, 1, 32'h77));

    for (int i = 0; i < v.size(); i++)
      apply(v[i], $sformatf("v%0d", i));

    chk("freeze_once", dlv77, 1);
    chk("flushed_dropped", dlvC, 0);

    // Stall window: load one record then hold it for 10 cycles
    apply(mk(1, 1, 0, 0, 0, 32'h0, 0, 1, 32'h0), "st_clr");
    apply(mk(0, 1, 0, 1, 0, 32'h99, 1, 1, 32'h99), "st_ld");
    for (int i = 0; i < 10; i++)
      apply(mk(0, 1, 0, 0, 0, 32'h0, 1, 1, 32'h99), $sformatf("st%0d", i));
`ifdef XM_STAGE_STALL_CNT_EN
    chk("stall_cnt_10", {16'd0, stall_cnt}, 32'd10);
    @(negedge clk);
    dut.stall_q = 16'hFFFE;
    apply(mk(0, 1, 0, 0, 0, 32'h0, 1, 1, 32'h99), "sat0");
    chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'hFFFF);
    apply(mk(0, 1, 1, 0, 0, 32'h0, 0, 1, 32'h99), "sat1");
    chk("stall_cnt_hold", {16'd0, stall_cnt}, 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
